wb_master_arbiter: RTL
======================

Name: wb_master_arbiter

Overview:
- Round-robin arbiter sharing the single ethmac Wishbone slave port (registers and buffer descriptors) between NUM_MASTERS testbench/host requesters, e.g. config sequencer and BD manager.
- Grants one master per Wishbone cycle, muxes its request onto the slave, and routes ack/err back to it.
- Watchdog aborts hung cycles with a synthesized err.
- Sits between the master driver BFMs and ethmac_if_pins slave signals.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4)
- ADDR_WIDTH, 10, word address width (byte address bits [11:2])
- DATA_WIDTH, 32, data bus width
- SEL_WIDTH, 4, byte-select width
- TIMEOUT_CYCLES, 256, max cycles with strobe asserted and no ack/err before abort

Ports:
- wb_clk_i  in  1  Wishbone clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master 0 in LSBs
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master err
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  ADDR_WIDTH  to slave
- s_sel_o  out  SEL_WIDTH  to slave
- s_dat_o  out  DATA_WIDTH  to slave
- s_dat_i  in  DATA_WIDTH  from slave
- s_ack_i, s_err_i  in  1 each  from slave
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle

Behaviour:
- Reset (async, wb_rst_n_i low):
  - state=IDLE, grant_o=0, rr pointer=0, watchdog=0.
  - All s_* control outputs 0; s_adr_o/s_sel_o/s_dat_o 0.
  - m_ack_o=0, m_err_o=0, m_dat_o=0.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - If any m_cyc_i set, register grant to the first requester at or after the rr pointer (wrapping modulo NUM_MASTERS), then go to BUSY.
  - Arbitration latency: 1 clock from m_cyc_i to s_cyc_o.
- BUSY:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o are combinational copies of the granted master's signals.
  - m_ack_o/m_err_o carry s_ack_i/s_err_i on the granted bit only; m_dat_o = s_dat_i. Non-granted acks/errs stay 0.
  - Granted master dropping m_cyc_i → IDLE next clock; rr pointer = granted index + 1 (wrap).
  - Exactly one dead cycle with s_cyc_o=0 between owners.
  - Back-to-back transfers within one held cyc stay with the owner, no re-arbitration.
- Watchdog:
  - Counts clocks in BUSY with s_stb_o=1 and s_ack_i=s_err_i=0; clears on ack, err, or stb low.
  - At count == TIMEOUT_CYCLES-1: pulse m_err_o of owner for 1 clock, force s_cyc_o=s_stb_o=0, go to ABORT.
- ABORT:
  - Slave outputs held 0; a late s_ack_i is ignored.
  - Stay until the owner drops m_cyc_i, then IDLE with rr pointer advanced.
- Simultaneous events:
  - s_ack_i on the same clock the watchdog expires: ack wins, no err, counter clears.
  - s_ack_i and s_err_i together: both forwarded unchanged.
- Reset mid-cycle: immediate return to reset values; an in-flight slave cycle is abandoned.

Optional Feature:
- Macro WB_ARB_LOCK_EN.
- Enabled:
  - Adds port m_lock_i (in, NUM_MASTERS).
  - If the owner has m_lock_i=1 when it drops m_cyc_i, grant is kept (state BUSY, s_cyc_o=0) until it reasserts cyc or drops lock; no dead cycle for the locked owner.
  - Watchdog does not count while s_cyc_o=0.
- Disabled: no m_lock_i port; behaviour exactly as above.

Decomposition:
- Shared package wb_arb_pkg holds:
  - arb_state_e enum {IDLE, BUSY, ABORT}.
  - Width localparams; TIMEOUT default constant.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module wb_arb_watchdog holds the counter, clear/enable inputs and expire output.

Test Plan:
- Single master 0 writes 0xDEADBEEF to addr 0x010, sel 0xF → s_adr_o=0x010, s_we_o=1, s_cyc_o rises 1 clock after m_cyc_i[0]; m_ack_o=2'b01 on slave ack.
- Both masters raise cyc on the same clock after reset → grant 01 first; after master 0 releases, one dead cycle, then grant 10; a third simultaneous request is granted back to 01.
- Master 1 reads addr 0x020 while master 0 waits, slave returns 0x12345678 → m_dat_o=0x12345678, m_ack_o=2'b10, m_ack_o[0] stays 0.
- Slave never acks, TIMEOUT_CYCLES=16 → m_err_o owner bit pulses at cycle 16 of strobe, s_cyc_o=0; a late s_ack_i is not forwarded.
- s_ack_i arrives exactly at watchdog expiry → ack forwarded, no err, state remains BUSY.
- wb_rst_n_i low mid-BUSY → all outputs 0 asynchronously, grant_o=0; after release, arbitration restarts with master 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared states, defaults and round-robin pick for wb_master_arbiter
package wb_arb_pkg;

    localparam int MAX_MASTERS     = 4;
    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int SEL_WIDTH_DEF   = 4;
    localparam int TIMEOUT_DEF     = 256;

    typedef logic [1:0] arb_state_e;
    localparam arb_state_e IDLE  = 2'd0;
    localparam arb_state_e BUSY  = 2'd1;
    localparam arb_state_e ABORT = 2'd2;

    // First requester at or after ptr, wrapping modulo n; returns one-hot (0 if none)
    function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                       input logic [1:0] ptr,
                                                       input int n);
        logic [MAX_MASTERS-1:0] g;
        logic found;
        int idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (!found && req[idx[1:0]]) begin
                    g[idx[1:0]] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stall counter that flags a hung Wishbone strobe
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    assign expire = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - round-robin Wishbone master arbiter with watchdog abort
// Optional owner lock (m_lock_i) enabled by defining WB_ARB_LOCK_EN.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int SEL_WIDTH      = SEL_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
`ifdef WB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]            m_lock_i,
`endif
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          nxt_ptr;
    logic [IW-1:0]          pick_idx;
    logic [MAX_MASTERS-1:0] req4;
    logic [MAX_MASTERS-1:0] pick;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   owner_lock;
    logic                   busy;
    logic                   wd_enable;
    logic                   wd_expire;

    assign busy      = (state == BUSY);
    assign owner_cyc = m_cyc_i[gidx];
    assign owner_stb = m_stb_i[gidx];
    assign grant_o   = grant;
    assign nxt_ptr   = (int'(gidx) == NUM_MASTERS - 1) ? '0 : gidx + 1'b1;

`ifdef WB_ARB_LOCK_EN
    assign owner_lock = m_lock_i[gidx];
`else
    assign owner_lock = 1'b0;
`endif

    always_comb begin
        req4                  = '0;
        req4[NUM_MASTERS-1:0] = m_cyc_i;
        pick                  = rr_pick(req4, 2'(ptr), NUM_MASTERS);
        pick_idx              = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // Raw owner strobe feeds the watchdog so the forced-low slave outputs cannot loop back
    assign wd_enable = busy && owner_cyc && owner_stb && !s_ack_i && !s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .enable(wd_enable),
        .clear (!wd_enable),
        .expire(wd_expire)
    );

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        if (busy && !wd_expire) begin
            s_cyc_o = owner_cyc;
            s_stb_o = owner_cyc && owner_stb;
            s_we_o  = m_we_i[gidx];
            s_adr_o = m_adr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            s_sel_o = m_sel_i[int'(gidx)*SEL_WIDTH +: SEL_WIDTH];
            s_dat_o = m_dat_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign m_ack_o = busy ? (grant & {NUM_MASTERS{s_ack_i}}) : '0;
    assign m_err_o = busy ? (grant & {NUM_MASTERS{s_err_i | wd_expire}}) : '0;
    assign m_dat_o = busy ? s_dat_i : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        grant <= pick[NUM_MASTERS-1:0];
                        gidx  <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (wd_expire) begin
                        state <= ABORT;
                    end else if (!owner_cyc && !owner_lock) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= nxt_ptr;
                    end
                end
                ABORT: begin
                    if (!owner_cyc) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= nxt_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
